// File: rtl/decode_pkg.sv
// Shared encodings and parameter limits for the decode sequencer.
// Mode values are plain 2-bit constants so legacy RTL can use them without enum casts.
package decode_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_DIRECT  = 2'd0;
    localparam mode_t MODE_SCAN    = 2'd1;
    localparam mode_t MODE_ONESHOT = 2'd2;
    localparam mode_t MODE_RSVD    = 2'd3;

    localparam int SEL_W_MIN = 1;
    localparam int SEL_W_MAX = 8;

    // Range check for integrators; returns 1 when a select width is supported.
    function automatic logic sel_w_legal(input int w);
        return (w >= SEL_W_MIN) && (w <= SEL_W_MAX);
    endfunction

endpackage

// File: rtl/decode_onehot.sv
// Combinational one-hot decoder: a single line of y follows address a while en is high.
// Purely combinational; the caller registers the result.
module decode_onehot #(
    parameter int SEL_W = 4,
    localparam int OUT_N = 2 ** SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] a,
    output logic [OUT_N-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/decode_seq.sv
// Decode sequencer: registered one-hot output driven either directly from sel or
// from an index register that scans (wrapping) or runs once (saturating with done).
module decode_seq
    import decode_pkg::*;
#(
    parameter int SEL_W = 4,
    localparam int OUT_N = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    input  logic             step,
    input  logic             dir,
    output logic [OUT_N-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             wrap,
    output logic             done
);

    localparam logic [SEL_W-1:0] IDX_ZERO = '0;
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;

    logic [OUT_N-1:0] y_q, y_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             dec_en;
    logic             step_ok;
    logic             at_term;
    logic [SEL_W-1:0] idx_stepped;

    // Steps are qualified by en; loads are not.
    assign step_ok     = step && en;
    assign idx_stepped = dir ? (idx_q + IDX_ONE) : (idx_q - IDX_ONE);
    assign at_term     = dir ? (idx_q == IDX_MAX) : (idx_q == IDX_ZERO);

    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        done_d = 1'b0;
        dec_en = en;
        case (mode)
            MODE_DIRECT: begin
                idx_d = sel;
            end
            MODE_SCAN: begin
                if (load) begin
                    idx_d = sel;
                end else if (step_ok) begin
                    idx_d  = idx_stepped;
                    wrap_d = at_term;
                end
            end
            MODE_ONESHOT: begin
                // done is a level; it only survives while staying in ONESHOT.
                done_d = done_q;
                if (load) begin
                    idx_d  = sel;
                    done_d = 1'b0;
                end else if (step_ok) begin
                    if (at_term) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d  = idx_stepped;
                        done_d = 1'b0;
                    end
                end
            end
            default: begin
                dec_en = 1'b0;
            end
        endcase
    end

    // Decode the index value being written this edge so y and idx stay aligned.
    decode_onehot #(
        .SEL_W(SEL_W)
    ) u_onehot (
        .en (dec_en),
        .a  (idx_d),
        .y  (y_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q    <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_decode_seq.sv
// Scoreboard bench for decode_seq (SEL_W=4): stimulus pushes hand-computed
// expectations, an independent monitor pops and compares one entry per edge.
module tb_decode_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic        load;
    logic        step;
    logic        dir;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
    logic        done;

    typedef struct {
        logic [15:0] y;
        logic [3:0]  idx;
        logic        wrap;
        logic        done;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    decode_seq #(.SEL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .step  (step),
        .dir   (dir),
        .y     (y),
        .idx   (idx),
        .wrap  (wrap),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, expv);
        end
    endtask

    // Monitor: every edge the DUT updates its registered outputs; compare one entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "y",    y,            e.y);
                chk(e.nm, "idx",  {12'd0, idx}, {12'd0, e.idx});
                chk(e.nm, "wrap", {15'd0, wrap}, {15'd0, e.wrap});
                chk(e.nm, "done", {15'd0, done}, {15'd0, e.done});
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic e_in, input logic [1:0] m, input logic [3:0] s,
                       input logic ld, input logic st, input logic d,
                       input logic [15:0] ey, input logic [3:0] ei, input logic ew, input logic ed,
                       input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = r; en = e_in; mode = m; sel = s; load = ld; step = st; dir = d;
        e.y = ey; e.idx = ei; e.wrap = ew; e.done = ed; e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_n;
        logic [15:0] one;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; sel = 4'd0; load = 1'b0; step = 1'b0; dir = 1'b1;
        one = 16'h0001;

        //   rst en mode sel ld st dir   y        idx  w  d
        cyc(0, 1, 2'd1, 4'd7, 1, 1, 1, 16'h0000, 4'd0, 0, 0, "reset");

        for (int s = 0; s < 16; s++) begin
            cyc(1, 1, 2'd0, 4'(s), 0, 0, 1, one << s, 4'(s), 0, 0, "direct_sweep");
        end
        cyc(1, 0, 2'd0, 4'd3, 0, 0, 1, 16'h0000, 4'd3, 0, 0, "direct_en0");

        cyc(1, 1, 2'd1, 4'd14, 1, 0, 1, 16'h4000, 4'd14, 0, 0, "scan_load14");
        cyc(1, 1, 2'd1, 4'd0,  0, 1, 1, 16'h8000, 4'd15, 0, 0, "scan_up15");
        cyc(1, 1, 2'd1, 4'd0,  0, 1, 1, 16'h0001, 4'd0,  1, 0, "scan_wrap0");
        cyc(1, 1, 2'd1, 4'd0,  0, 1, 1, 16'h0002, 4'd1,  0, 0, "scan_up1");
        cyc(1, 1, 2'd1, 4'd0,  0, 0, 1, 16'h0002, 4'd1,  0, 0, "scan_idle");
        cyc(1, 1, 2'd1, 4'd0,  1, 0, 1, 16'h0001, 4'd0,  0, 0, "scan_load0");
        cyc(1, 1, 2'd1, 4'd0,  0, 1, 0, 16'h8000, 4'd15, 1, 0, "scan_dn_wrap");
        cyc(1, 1, 2'd1, 4'd0,  0, 0, 0, 16'h8000, 4'd15, 0, 0, "scan_wrap_drop");

        cyc(1, 1, 2'd2, 4'd13, 1, 0, 1, 16'h2000, 4'd13, 0, 0, "os_load13");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 1, 16'h4000, 4'd14, 0, 0, "os_up14");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 1, 16'h8000, 4'd15, 0, 0, "os_up15");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 1, 16'h8000, 4'd15, 0, 1, "os_term");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 1, 16'h8000, 4'd15, 0, 1, "os_term_hold");
        cyc(1, 1, 2'd2, 4'd2,  1, 0, 1, 16'h0004, 4'd2,  0, 0, "os_load2");
        cyc(1, 1, 2'd2, 4'd0,  1, 0, 1, 16'h0001, 4'd0,  0, 0, "os_load0");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 0, 16'h0001, 4'd0,  0, 1, "os_term_dn");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 1, 16'h0002, 4'd1,  0, 0, "os_step_away");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 0, 16'h0001, 4'd0,  0, 0, "os_dn0");
        cyc(1, 1, 2'd2, 4'd0,  0, 1, 0, 16'h0001, 4'd0,  0, 1, "os_term_dn2");
        cyc(1, 1, 2'd1, 4'd0,  0, 0, 0, 16'h0001, 4'd0,  0, 0, "os_leave");

        cyc(1, 1, 2'd1, 4'd5,  1, 1, 1, 16'h0020, 4'd5,  0, 0, "load_wins");
        cyc(1, 0, 2'd1, 4'd0,  0, 1, 1, 16'h0000, 4'd5,  0, 0, "step_en0");
        cyc(1, 0, 2'd1, 4'd7,  1, 0, 1, 16'h0000, 4'd7,  0, 0, "load_en0");
        cyc(1, 1, 2'd1, 4'd0,  0, 0, 1, 16'h0080, 4'd7,  0, 0, "en_back");

        cyc(1, 1, 2'd3, 4'd2,  1, 1, 1, 16'h0000, 4'd7,  0, 0, "rsvd_hold");
        cyc(1, 1, 2'd1, 4'd2,  0, 0, 1, 16'h0080, 4'd7,  0, 0, "rsvd_to_scan");
        cyc(1, 1, 2'd0, 4'd9,  0, 0, 1, 16'h0200, 4'd9,  0, 0, "enter_direct");
        cyc(1, 1, 2'd1, 4'd2,  0, 0, 1, 16'h0200, 4'd9,  0, 0, "scan_at9");
        cyc(0, 1, 2'd1, 4'd4,  1, 1, 1, 16'h0000, 4'd0,  0, 0, "reset_mid_scan");
        cyc(1, 1, 2'd1, 4'd4,  0, 1, 1, 16'h0002, 4'd1,  0, 0, "post_reset_step");

        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_seq.md
DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 Parameter SEL_W, default 4, select/index width in bits; legal range 1..8.
REQ-002 Parameter OUT_N, default 2**SEL_W, output line count; derived only, never overridden.
REQ-003 clk  input  1  rising-edge clock; the only clock in the block.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 en  input  1  output enable; 0 forces all y lines low.
REQ-006 mode  input  2  0=DIRECT, 1=SCAN (wrapping), 2=ONESHOT (non-wrapping), 3=reserved.
REQ-007 sel  input  SEL_W  decode address in DIRECT; load value in SCAN/ONESHOT.
REQ-008 load  input  1  SCAN/ONESHOT: idx <= sel on the next edge.
REQ-009 step  input  1  SCAN/ONESHOT: advance idx by one on the next edge.
REQ-010 dir  input  1  step direction; 1=up, 0=down.
REQ-011 y  output  OUT_N  registered one-hot (or all-zero) decode.
REQ-012 idx  output  SEL_W  current index register.
REQ-013 wrap  output  1  one-cycle pulse on SCAN wrap-around.
REQ-014 done  output  1  ONESHOT terminal flag, level.

Function
REQ-015 Every output SHALL be registered; y reflects the inputs/idx from the previous edge, i.e. one-cycle latency.
REQ-016 DIRECT: y SHALL be onehot(sel) when en=1 and all zero when en=0; idx SHALL track sel; wrap=0; done=0.
REQ-017 SCAN/ONESHOT: y SHALL be onehot(idx_next) when en=1 and all zero when en=0, where idx_next is the value idx takes at the same edge.
REQ-018 SCAN step: idx SHALL become (idx+1) mod OUT_N when dir=1 and (idx-1) mod OUT_N when dir=0.
REQ-019 SCAN wrap: the pulse SHALL assert for exactly one cycle when a step moves OUT_N-1->0 (up) or 0->OUT_N-1 (down).
REQ-020 ONESHOT: a step at terminal (OUT_N-1 up, 0 down) SHALL leave idx unchanged and set done=1; wrap SHALL stay 0.
REQ-021 ONESHOT: done SHALL clear on load, on a step away from terminal, or on leaving ONESHOT mode.
REQ-022 load and step in the same cycle: load SHALL win and step SHALL be ignored.
REQ-023 step with en=0 SHALL be ignored; load with en=0 SHALL be accepted.
REQ-024 Mode change SHALL retain idx except on entry to DIRECT, where idx follows sel.
REQ-025 mode=3 SHALL drive y=0, wrap=0, done=0 and hold idx.
REQ-026 SEL_W=1 SHALL behave identically, with OUT_N=2.

Reset
REQ-027 With rst_n=0 at a rising edge: y=0, idx=0, wrap=0, done=0; all other inputs ignored.
REQ-028 Reset asserted mid-scan SHALL discard pending load/step; the first edge after release SHALL act on that cycle's inputs only.

Structure
REQ-029 Package decode_pkg SHALL hold the mode encodings (MODE_DIRECT, MODE_SCAN, MODE_ONESHOT, MODE_RSVD) and the SEL_W range limits.
REQ-030 The combinational one-hot decode SHALL live in the sub-module decode_onehot (params SEL_W; in: en, a; out: y), with no storage.
REQ-031 decode_seq SHALL contain the index register, mode control and output registers.

Verification (SEL_W=4)
REQ-032 DIRECT, en=1, sel=0..15 swept -> y=1<<sel one cycle later; en=0 -> y=0 next cycle.
REQ-033 SCAN, load sel=14, then step dir=1 x3 -> idx 15,0,1; wrap high only in the cycle idx=0; y=16'h8000,16'h0001,16'h0002.
REQ-034 SCAN, idx=0, step dir=0 -> idx=15, wrap=1 for one cycle, y=16'h8000.
REQ-035 ONESHOT, load 13, step up x4 -> idx 14,15,15,15; done=1 from the third step; wrap=0 throughout; then load 2 -> done=0, idx=2.
REQ-036 Same-cycle load=1 sel=5 and step=1 -> idx=5; step with en=0 -> idx unchanged, y=0.
REQ-037 rst_n=0 during SCAN at idx=9 -> all outputs 0 after that edge; mode=3 -> y=0 with idx held.
